// File: rtl/sevseg_pkg.sv
// Shared segment codes and decode result type for the seven-segment scan decoder.
package sevseg_pkg;
  localparam int SEG_W = 7;

  // Active-low, bit 6 = a ... bit 0 = g
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0001100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg_dec_t;
endpackage

// File: rtl/sevseg_pattern_dec.sv
// Combinational decode of one active-low segment pattern to a hex nibble.
module sevseg_pattern_dec
  import sevseg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output seg_dec_t         dec
);

  always_comb begin
    dec = '{nibble: 4'h0, blank: 1'b0, err: 1'b0};
    case (seg)
      SEG_0:     dec.nibble = 4'h0;
      SEG_1:     dec.nibble = 4'h1;
      SEG_2:     dec.nibble = 4'h2;
      SEG_3:     dec.nibble = 4'h3;
      SEG_4:     dec.nibble = 4'h4;
      SEG_5:     dec.nibble = 4'h5;
      SEG_6:     dec.nibble = 4'h6;
      SEG_7:     dec.nibble = 4'h7;
      SEG_8:     dec.nibble = 4'h8;
      SEG_9:     dec.nibble = 4'h9;
      SEG_A:     dec.nibble = 4'hA;
      SEG_B:     dec.nibble = 4'hB;
      SEG_C:     dec.nibble = 4'hC;
      SEG_D:     dec.nibble = 4'hD;
      SEG_E:     dec.nibble = 4'hE;
      SEG_F:     dec.nibble = 4'hF;
      SEG_BLANK: dec.blank  = 1'b1;
      default:   dec.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment drive and publishes frames.
// Optional SEVDEC_ERRCNT_EN adds err_cnt_o, a saturating count of frames with any error digit.
module sevseg_scan_decoder
  import sevseg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an_i,
  input  logic [SEG_W-1:0]  seg_i,
  output logic [4*NDIG-1:0] value_o,
  output logic [NDIG-1:0]   blank_o,
  output logic [NDIG-1:0]   err_o,
  output logic              frame_o
`ifdef SEVDEC_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt_o
`endif
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [NDIG-1:0]      s_an, sel, seen, seen_nxt;
  logic [SEG_W-1:0]     s_seg;
  logic [CW-1:0]        cnt;
  logic                 same, cap, done;
  seg_dec_t             dec;
  logic [NDIG-1:0][3:0] nib_q, nib_nxt;
  logic [NDIG-1:0]      blank_q, blank_nxt, err_q, err_nxt;

  sevseg_pattern_dec u_dec (
    .seg (s_seg),
    .dec (dec)
  );

  // Incoming sample matching the registered one extends the dwell; the capture
  // edge therefore also requires the pair to still be held on that edge.
  assign same = ({an_i, seg_i} == {s_an, s_seg});
  assign sel  = ~s_an;
  assign cap  = same && $onehot(sel) && (cnt == CW'(STABLE_CYC - 1));

  always_comb begin
    seen_nxt  = seen;
    nib_nxt   = nib_q;
    blank_nxt = blank_q;
    err_nxt   = err_q;
    for (int k = 0; k < NDIG; k++) begin
      if (cap && sel[k]) begin
        nib_nxt[k]   = dec.nibble;
        blank_nxt[k] = dec.blank;
        err_nxt[k]   = dec.err;
        seen_nxt[k]  = 1'b1;
      end
    end
  end

  assign done = cap && (&seen_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an    <= '1;
      s_seg   <= '0;
      cnt     <= '0;
      seen    <= '0;
      nib_q   <= '0;
      blank_q <= '0;
      err_q   <= '0;
      value_o <= '0;
      blank_o <= '0;
      err_o   <= '0;
      frame_o <= 1'b0;
    end else begin
      s_an    <= an_i;
      s_seg   <= seg_i;
      if (!same)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYC))
        cnt <= cnt + CW'(1);
      nib_q   <= nib_nxt;
      blank_q <= blank_nxt;
      err_q   <= err_nxt;
      seen    <= done ? '0 : seen_nxt;
      frame_o <= done;
      if (done) begin
        value_o <= nib_nxt;
        blank_o <= blank_nxt;
        err_o   <= err_nxt;
      end
    end
  end

`ifdef SEVDEC_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_o <= '0;
    else if (done && (|err_nxt) && (err_cnt_o != 8'hFF))
      err_cnt_o <= err_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Directed-vector bench for sevseg_scan_decoder (NDIG=4, STABLE_CYC=4).
module tb_sevseg_scan_decoder;
  localparam int NDIG = 4;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0001100, SA = 7'b0001000, SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001, SD = 7'b1000010, SE = 7'b0110000;
  localparam logic [6:0] SF = 7'b0111000, SBL = 7'b1111111, SBAD = 7'b1111110;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NDIG-1:0]   an_i = '1;
  logic [6:0]        seg_i = 7'h7F;
  logic [4*NDIG-1:0] value_o;
  logic [NDIG-1:0]   blank_o, err_o;
  logic              frame_o;
`ifdef SEVDEC_ERRCNT_EN
  logic [7:0]        err_cnt_o;
`endif

  int nvec = 0;
  int nbad = 0;
  int nframe = 0;

  sevseg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .an_i    (an_i),
    .seg_i   (seg_i),
    .value_o (value_o),
    .blank_o (blank_o),
    .err_o   (err_o),
    .frame_o (frame_o)
`ifdef SEVDEC_ERRCNT_EN
    ,
    .err_cnt_o (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_o === 1'b1) nframe++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic dwell(input logic [NDIG-1:0] an, input logic [6:0] seg, input int n);
    an_i  = an;
    seg_i = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic dig(input int k, input logic [6:0] seg, input int n);
    logic [NDIG-1:0] an;
    an = '1;
    an[k] = 1'b0;
    dwell(an, seg, n);
  endtask

  task automatic idle(input int n);
    dwell('1, 7'h7F, n);
  endtask

  int f0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_value", 32'(value_o), 32'h0);
    chk("rst_blank", 32'(blank_o), 32'h0);
    chk("rst_err",   32'(err_o),   32'h0);
    chk("rst_frame", 32'(frame_o), 32'h0);
    rst_n = 1'b1;
    idle(3);

    // basic scan 1,2,3,4
    f0 = nframe;
    dig(0, S1, 10); dig(1, S2, 10); dig(2, S3, 10); dig(3, S4, 10);
    idle(3);
    chk("scan_frames", 32'(nframe - f0), 32'd1);
    chk("scan_value",  32'(value_o), 32'h4321);
    chk("scan_blank",  32'(blank_o), 32'h0);
    chk("scan_err",    32'(err_o),   32'h0);

    // blank and undecodable digits
    f0 = nframe;
    dig(0, SBAD, 6); dig(1, S5, 6); dig(2, SBL, 6); dig(3, SF, 6);
    idle(3);
    chk("be_frames", 32'(nframe - f0), 32'd1);
    chk("be_value",  32'(value_o), 32'hF050);
    chk("be_blank",  32'(blank_o), 32'b0100);
    chk("be_err",    32'(err_o),   32'b0001);

    // short dwells on digit 1 (3 and 4 cycles) are ignored; 5-cycle dwells count
    f0 = nframe;
    dig(0, SA, 5); dig(1, SB, 5); dig(1, S8, 3); dig(1, S9, 4);
    dig(2, SC, 5); dig(3, SD, 5);
    idle(3);
    chk("gl_frames", 32'(nframe - f0), 32'd1);
    chk("gl_value",  32'(value_o), 32'hDCBA);

    // multi-select is idle mid-scan
    f0 = nframe;
    dig(0, S7, 6); dig(1, S6, 6);
    dwell(4'b0011, S8, 20);
    chk("ms_noframe", 32'(nframe - f0), 32'd0);
    chk("ms_hold",    32'(value_o), 32'hDCBA);
    dig(2, SE, 6); dig(3, S9, 6);
    idle(3);
    chk("ms_frames", 32'(nframe - f0), 32'd1);
    chk("ms_value",  32'(value_o), 32'h9E67);

    // reset mid-frame discards the partial frame
    dig(0, S1, 6); dig(1, S2, 6);
    rst_n = 1'b0;
    #1;
    chk("mr_value", 32'(value_o), 32'h0);
    chk("mr_blank", 32'(blank_o), 32'h0);
    chk("mr_err",   32'(err_o),   32'h0);
    chk("mr_frame", 32'(frame_o), 32'h0);
`ifdef SEVDEC_ERRCNT_EN
    chk("mr_errcnt", 32'(err_cnt_o), 32'h0);
`endif
    @(negedge clk);
    an_i = '1; seg_i = 7'h7F;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    f0 = nframe;
    dig(2, S3, 6); dig(3, S4, 6);
    idle(3);
    chk("mr_partial", 32'(nframe - f0), 32'd0);
    dig(0, S5, 6); dig(1, S6, 6);
    idle(3);
    chk("mr_frames", 32'(nframe - f0), 32'd1);
    chk("mr_full",   32'(value_o), 32'h4365);

`ifdef SEVDEC_ERRCNT_EN
    for (int i = 0; i < 300; i++) begin
      dig(0, SBAD, 5); dig(1, S1, 5); dig(2, S2, 5); dig(3, S3, 5);
    end
    idle(3);
    chk("errcnt_sat", 32'(err_cnt_o), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
